// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared types and helpers for the main-memory responder.
//   mem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   offset_bits : byte-offset bits in an address for a given word width
//   idx_bits    : word-index bits for a given memory depth
//   mem_req_t   : cache-to-memory request bundle (default 32-bit address/data)
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    localparam int unsigned MemAddrWidth = 32;
    localparam int unsigned MemDataWidth = 32;

    function automatic int unsigned offset_bits(input int unsigned data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 0;
    endfunction

    // A single-word memory still needs a 1-bit index to keep slices legal.
    function automatic int unsigned idx_bits(input int unsigned mem_words);
        return (mem_words > 1) ? $clog2(mem_words) : 1;
    endfunction

    typedef struct packed {
        logic                        write;
        logic [MemAddrWidth-1:0]     addr;
        logic [MemDataWidth-1:0]     wdata;
        logic [MemDataWidth/8-1:0]   wstrb;
    } mem_req_t;

endpackage

// File: rtl/main_mem_array.sv
// main_mem_array: word-addressed storage with byte-strobed synchronous write and
// a registered read that is sampled on the access edge.
//   clk_i, rst_ni : clock, async active-low reset (read register only)
//   access_i      : perform the access on this edge
//   write_i       : 1 = write, 0 = read
//   drop_i        : suppress the write and return zero (out-of-range access)
//   idx_i         : word index
//   wdata_i       : write data
//   wstrb_i       : byte-lane write enables
//   rdata_o       : read data of the last access (0 after a write or drop)
module main_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned IDX_WIDTH  = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    access_i,
    input  logic                    write_i,
    input  logic                    drop_i,
    input  logic [IDX_WIDTH-1:0]    idx_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned Strb = DATA_WIDTH / 8;

    // Contents are deliberately left unreset.
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (access_i && write_i && !drop_i) begin
            for (int b = 0; b < Strb; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (access_i) begin
            rdata_q <= (write_i || drop_i) ? '0 : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: memory end of the cache-to-memory request interface. Accepts one
// read/write request at a time, waits a fixed LATENCY, then returns read data or a
// write acknowledge over a valid/ready response channel.
//   clk_i, rst_ni           : clock, async active-low reset
//   req_valid_i/req_ready_o : request handshake
//   req_write_i, req_addr_i, req_wdata_i, req_wstrb_i : request payload
//   resp_valid_o/resp_ready_i : response handshake
//   resp_rdata_o            : read data (0 for writes)
//   busy_o                  : request in flight
//   resp_err_o              : out-of-range access flag (only with MAIN_MEM_RESP_ERR_EN)
// Optional feature macro: MAIN_MEM_RESP_ERR_EN. Without it, upper address bits wrap.
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_WORDS     = 1024,
    parameter int unsigned LATENCY       = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]    req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]  req_wstrb_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [DATA_WIDTH-1:0]    resp_rdata_o,
`ifdef MAIN_MEM_RESP_ERR_EN
    output logic                     resp_err_o,
`endif
    output logic                     busy_o
);

    localparam int unsigned Offset = offset_bits(DATA_WIDTH);
    localparam int unsigned Idx    = idx_bits(MEM_WORDS);
    localparam int unsigned CntW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

    mem_state_e state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    write_q;
    logic [Idx-1:0]          idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    drop_q;
    logic                    req_fire;
    logic                    access;
    logic                    out_of_range;
    logic                    unused_addr_bits;

    // Gated by reset so the requester never sees ready while held in reset.
    assign req_ready_o  = (state_q == IDLE) & rst_ni;
    assign req_fire     = req_valid_i & req_ready_o;
    assign resp_valid_o = (state_q == RESP);
    assign busy_o       = (state_q != IDLE);

    // Byte-offset bits (and upper bits when wrapping) do not select a word.
    assign unused_addr_bits = ^req_addr_i;

`ifdef MAIN_MEM_RESP_ERR_EN
    assign out_of_range = (req_addr_i >> (Offset + Idx)) != '0;
`else
    assign out_of_range = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = WAIT;
                    cnt_d   = CntLoad;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // The memory is touched only here, so a reset in WAIT discards the write.
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            drop_q  <= 1'b0;
        end else if (req_fire) begin
            write_q <= req_write_i;
            idx_q   <= req_addr_i[Offset +: Idx];
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
            drop_q  <= out_of_range;
        end
    end

`ifdef MAIN_MEM_RESP_ERR_EN
    logic resp_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_err_q <= 1'b0;
        end else if (access) begin
            resp_err_q <= drop_q;
        end
    end

    assign resp_err_o = resp_err_q;
`endif

    main_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .IDX_WIDTH  (Idx)
    ) u_array (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .access_i (access),
        .write_i  (write_q),
        .drop_i   (drop_q),
        .idx_i    (idx_q),
        .wdata_i  (wdata_q),
        .wstrb_i  (wstrb_q),
        .rdata_o  (resp_rdata_o)
    );

endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed stimulus against a transaction-level model of the
// responder (one outstanding request, response due LATENCY edges after acceptance,
// memory committed on the due edge), plus literal expectations for key results.
module tb_main_mem_responder;

    localparam int unsigned L  = 4;
    localparam int unsigned MW = 1024;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b0;
    logic        req_valid_i  = 1'b0;
    logic        req_write_i  = 1'b0;
    logic [31:0] req_addr_i   = '0;
    logic [31:0] req_wdata_i  = '0;
    logic [3:0]  req_wstrb_i  = '0;
    logic        resp_ready_i = 1'b1;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        busy_o;
`ifdef MAIN_MEM_RESP_ERR_EN
    logic        resp_err_o;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    main_mem_responder #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_WORDS     (MW),
        .LATENCY       (L)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_wstrb_i  (req_wstrb_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
`ifdef MAIN_MEM_RESP_ERR_EN
        .resp_err_o   (resp_err_o),
`endif
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model and per-cycle compare ----------------
    logic [31:0] mm [MW];
    bit          pend = 1'b0;
    int          due  = 0;
    bit          m_write;
    bit          m_err;
    int          m_idx;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] exp_rdata;
    bit          ev;

    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            pend = 1'b0;
            check("rst_req_ready", req_ready_o, 0);
            check("rst_resp_valid", resp_valid_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_rdata", resp_rdata_o, 0);
`ifdef MAIN_MEM_RESP_ERR_EN
            check("rst_err", resp_err_o, 0);
`endif
        end else begin
            ev = pend && (cyc >= due);
            check("req_ready", req_ready_o, !pend);
            check("busy", busy_o, pend);
            check("resp_valid", resp_valid_o, ev);
            if (ev) begin
                check("resp_rdata", resp_rdata_o, exp_rdata);
`ifdef MAIN_MEM_RESP_ERR_EN
                check("resp_err", resp_err_o, m_err);
`endif
            end
            if (pend && cyc == due && m_write && !m_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_wstrb[b]) mm[m_idx][8*b +: 8] = m_wdata[8*b +: 8];
                end
            end
            if (ev && resp_ready_i) begin
                pend = 1'b0;
            end else if (!pend && req_valid_i) begin
                pend    = 1'b1;
                due     = cyc + 1 + L;
                m_write = req_write_i;
                m_idx   = int'((req_addr_i >> 2) % MW);
                m_wdata = req_wdata_i;
                m_wstrb = req_wstrb_i;
`ifdef MAIN_MEM_RESP_ERR_EN
                m_err   = (req_addr_i >> 12) != 0;
`else
                m_err   = 1'b0;
`endif
                exp_rdata = (m_write || m_err) ? 32'h0 : mm[m_idx];
            end
        end
    end

    // Counts busy cycles during the back-to-back window.
    bit bb_en   = 1'b0;
    int bb_busy = 0;
    initial forever begin
        @(negedge clk_i);
        if (bb_en && busy_o) bb_busy++;
    end

    // ---------------- driver tasks (called at posedge + #1) ----------------
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int hs);
        int t;
        t = 0;
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = d;
        req_wstrb_i = s;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        while (!req_ready_o && t < 100) begin
            t++;
            @(negedge clk_i);
        end
        tests++;
        if (t >= 100) begin
            fails++;
            $display("FAIL req_accept: req_ready_o stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        hs = cyc;
    endtask

    task automatic wait_resp(input int hs, output logic [31:0] rd, output int lat);
        int t;
        t = 0;
        @(negedge clk_i);
        while (!resp_valid_o && t < 100) begin
            t++;
            @(negedge clk_i);
        end
        tests++;
        if (t >= 100) begin
            fails++;
            $display("FAIL resp_arrive: resp_valid_o stayed 0 for %0d cycles, required 1", t);
        end
        lat = cyc - hs;
        rd  = resp_rdata_o;
        if (resp_ready_i) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // hold > 0: keep resp_ready_i low for hold cycles and poke a request while busy.
    task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold,
                          output logic [31:0] rd, output int lat);
        int hs;
        resp_ready_i = (hold == 0);
        issue(w, a, d, s, hs);
        wait_resp(hs, rd, lat);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk_i);
                #1;
                req_valid_i = (i == 0);
                req_write_i = 1'b1;
                req_addr_i  = 32'h20;
                req_wdata_i = 32'h0BAD0BAD;
                req_wstrb_i = 4'hF;
            end
            req_valid_i  = 1'b0;
            resp_ready_i = 1'b1;
            @(posedge clk_i);
            #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rd;
    int          lat;
    int          hs0, hs1, hs2;

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Full-word write then read back.
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, lat);
        check("wr_latency", lat, 4);
        check("wr_ack_rdata", rd, 32'h0);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, lat);
        check("rd_latency", lat, 4);
        check("rd_full", rd, 32'hDEADBEEF);

        // Partial-strobe write keeps the upper lanes.
        do_txn(1'b1, 32'h10, 32'h00001234, 4'h3, 0, rd, lat);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, lat);
        check("rd_partial", rd, 32'hDEAD1234);

        // Zero strobe: acknowledged, no change.
        do_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, lat);
        check("wstrb0_ack", rd, 32'h0);

        // Backpressure with a request poked while busy.
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 3, rd, lat);
        check("bp_rdata", rd, 32'hDEAD1234);

        // Reset two cycles into WAIT discards the write.
        issue(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, hs0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_busy", busy_o, 0);
        check("midrst_ready", req_ready_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, lat);
        check("rd_after_rst", rd, 32'hDEAD1234);

        // Upper address bits: wrap, or error when the checker is built in.
        do_txn(1'b1, 32'h1010, 32'h11112222, 4'hF, 0, rd, lat);
        check("wrap_wr_latency", lat, 4);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, lat);
`ifdef MAIN_MEM_RESP_ERR_EN
        check("wrap_rd", rd, 32'hDEAD1234);
`else
        check("wrap_rd", rd, 32'h11112222);
`endif

        // Back-to-back reads with resp_ready_i tied high.
        do_txn(1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, 0, rd, lat);
        do_txn(1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, 0, rd, lat);
        do_txn(1'b1, 32'h8, 32'hC2C2C2C2, 4'hF, 0, rd, lat);
        resp_ready_i = 1'b1;
        bb_en = 1'b1;
        issue(1'b0, 32'h0, 32'h0, 4'h0, hs0);
        issue(1'b0, 32'h4, 32'h0, 4'h0, hs1);
        issue(1'b0, 32'h8, 32'h0, 4'h0, hs2);
        wait_resp(hs2, rd, lat);
        bb_en = 1'b0;
        check("b2b_last_rdata", rd, 32'hC2C2C2C2);
        check("b2b_gap01", hs1 - hs0, L + 2);
        check("b2b_gap12", hs2 - hs1, L + 2);
        check("b2b_busy_cycles", bb_busy, 15);

        repeat (3) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
